// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame instead of 10).
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 1000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    // tx_done is registered, so it is raised one count early to land in the final clk
    localparam logic [BaudW-1:0] BaudDone = BaudW'(ClksPerBit - 2);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             baud_last;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign baud_last = (baud_q == BaudLast);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    baud_d   = '0;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`endif
            StStop: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                    done_d = (baud_q == BaudDone);
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=16: table of bytes plus corner sequences,
// with a line monitor that decodes frames and compares them against a queue of expected bytes.
module tb_uart_tx;
    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int         checks = 0;
    int         errors = 0;
    int         frames = 0;
    vec_t       exp_q[$];
    int         gap_q[$];
    logic [NB-1:0] last_bits;
    vec_t       vecs[9];

    uart_tx #(
        .CLK_FREQ (16),
        .BAUD_RATE(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        vec_t e;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        e.data   = d;
        e.par    = p;
        exp_q.push_back(e);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (FRAME + 2) @(negedge clk);
    endtask

    // Line monitor: every level held CPB clks, busy throughout, one done pulse in the last clk
    initial begin : monitor
        int            idle_cnt;
        int            bad_lvl;
        int            bad_busy;
        int            n_done;
        int            pos_done;
        int            b;
        bit            aborted;
        logic [NB-1:0] bits;
        vec_t          e;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                idle_cnt = 0;
            end else if (tx === 1'b0) begin
                gap_q.push_back(idle_cnt);
                bad_lvl  = 0;
                bad_busy = 0;
                n_done   = 0;
                pos_done = -1;
                aborted  = 1'b0;
                bits     = '0;
                for (int n = 0; n < FRAME; n++) begin
                    if (n > 0) @(negedge clk);
                    if (rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = n / CPB;
                    if (n % CPB == 0) bits[b] = tx;
                    else if (tx !== bits[b]) bad_lvl++;
                    if (tx_busy !== 1'b1) bad_busy++;
                    if (tx_done === 1'b1) begin
                        n_done++;
                        pos_done = n;
                    end
                end
                if (aborted) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    idle_cnt = 0;
                end else begin
                    frames++;
                    last_bits = bits;
                    chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("data_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
`endif
                    end
                    chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
                    chk("bit_hold", bad_lvl, 0);
                    chk("busy_in_frame", bad_busy, 0);
                    chk("done_count", n_done, 1);
                    chk("done_position", pos_done, FRAME - 1);
                    @(negedge clk);
                    chk("idle_after_busy", {31'd0, tx_busy}, 32'd0);
                    chk("idle_after_tx", {31'd0, tx}, 32'd1);
                    idle_cnt = (tx === 1'b1) ? 1 : 0;
                end
            end else begin
                idle_cnt++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int   f0;
        vec_t e;
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'h55, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h5A, 1'b0};
        vecs[7] = '{8'h81, 1'b0};
        vecs[8] = '{8'h80, 1'b1};

        rst      = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #12;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, tx_busy}, 32'd0);
        chk("reset_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].data, vecs[i].par);
            if (i == 0)
                chk("a5_frame_bits", {22'd0, last_bits[NB-1], last_bits[8:0]},
                    {22'd0, 1'b1, 8'hA5, 1'b0});
        end
        chk("table_frames", frames, 9);

        // Request during bit 3 of a 0x00 frame must be dropped
        f0 = frames;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        e        = '{8'h00, 1'b0};
        exp_q.push_back(e);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (CPB * 4 + 5) @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (FRAME + 40) @(negedge clk);
        chk("midframe_frames", frames - f0, 1);
        chk("midframe_queue", exp_q.size(), 0);

        // tx_start held high: frames repeat with exactly one idle clk between them
        gap_q.delete();
        f0 = frames;
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        e        = '{8'h3C, 1'b0};
        repeat (3) exp_q.push_back(e);
        repeat (2 * (FRAME + 1) + FRAME / 2) @(negedge clk);
        tx_start = 1'b0;
        repeat (FRAME + 20) @(negedge clk);
        chk("b2b_frames", frames - f0, 3);
        chk("b2b_gap_count", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            chk("b2b_gap1", gap_q[1], 1);
            chk("b2b_gap2", gap_q[2], 1);
        end
        chk("b2b_queue", exp_q.size(), 0);

        // Asynchronous reset during bit 5, then a clean 0x81 frame
        f0 = frames;
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        e        = '{8'hC3, 1'b0};
        exp_q.push_back(e);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (CPB * 6 + 4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("async_rst_done", {31'd0, tx_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_tx", {31'd0, tx}, 32'd1);
        chk("aborted_no_frame", frames - f0, 0);
        send(8'h81, 1'b0);
        chk("post_rst_frames", frames - f0, 1);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
